cal_mod_counter: RTL and testbench

//  Parametrised modulo counter for the calendar datapath (seconds/minutes/hours/day/month).
//  - Runtime-programmable wrap limit (e.g. month lengths 28/29/30/31), configurable start value,

---
 rtl/cal_pkg.sv | 30 +++
 rtl/cal_cnt_next.sv | 74 +++++++
 rtl/cal_mod_counter.sv | 69 ++++++
 tb/tb_cal_mod_counter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// Shared calendar constants, the counter operation encoding, and a month-length helper.
package cal_pkg;

  localparam int CAL_SEC_LIM  = 59;
  localparam int CAL_MIN_LIM  = 59;
  localparam int CAL_HOUR_LIM = 23;
  localparam int CAL_MON_LIM  = 12;

  localparam int CAL_FEB_DAYS       = 28;
  localparam int CAL_FEB_LEAP_DAYS  = 29;
  localparam int CAL_SHORT_MON_DAYS = 30;
  localparam int CAL_LONG_MON_DAYS  = 31;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_LOAD,
    CNT_UP,
    CNT_DOWN
  } cnt_op_e;

  // Day-counter limit for a 1-based month; feeds the lim input of the day stage.
  function automatic int cal_month_days(input int month, input logic leap);
    int days;
    days = CAL_LONG_MON_DAYS;
    if (month == 2) days = leap ? CAL_FEB_LEAP_DAYS : CAL_FEB_DAYS;
    else if (month == 4 || month == 6 || month == 9 || month == 11) days = CAL_SHORT_MON_DAYS;
    return days;
  endfunction

endpackage

// File: rtl/cal_cnt_next.sv
// Combinational next-count, carry and load-error logic for one calendar counter stage.
module cal_cnt_next
  import cal_pkg::*;
#(
  parameter int BITS    = 5,
  parameter int MIN_VAL = 0
) (
  input  logic            en,
  input  logic            ld,
  input  logic            dn,
  input  logic [BITS-1:0] count,
  input  logic [BITS-1:0] ld_val,
  input  logic [BITS-1:0] lim,
  output logic [BITS-1:0] count_next,
  output logic            carry,
  output logic            ld_err_next
);

  localparam logic [BITS-1:0] MIN_V = BITS'(MIN_VAL);
  localparam logic [BITS-1:0] ONE_V = BITS'(1);

  logic [BITS-1:0] elim;
  logic [BITS:0]   inc;
  logic [BITS-1:0] dec;
  cnt_op_e         op;

  // A limit below the first value would leave no valid range; clamp it up.
  assign elim = (lim < MIN_V) ? MIN_V : lim;
  assign inc  = {1'b0, count} + {1'b0, ONE_V};
  assign dec  = count - ONE_V;

  always_comb begin
    op = CNT_HOLD;
    if (ld)      op = CNT_LOAD;
    else if (en) op = dn ? CNT_DOWN : CNT_UP;
  end

  always_comb begin
    count_next  = count;
    carry       = 1'b0;
    ld_err_next = 1'b0;
    case (op)
      CNT_LOAD: begin
        if (ld_val >= MIN_V && ld_val <= elim) begin
          count_next = ld_val;
        end else begin
          count_next  = MIN_V;
          ld_err_next = 1'b1;
        end
      end
      CNT_UP: begin
        // The overflow bit can only be set when count is already at or past elim.
        if (count >= elim || inc[BITS]) begin
          count_next = MIN_V;
          carry      = 1'b1;
        end else begin
          count_next = inc[BITS-1:0];
        end
      end
      CNT_DOWN: begin
        if (count <= MIN_V) begin
          count_next = elim;
          carry      = 1'b1;
        end else if (count > elim) begin
          count_next = elim;
        end else begin
          count_next = dec;
        end
      end
      default: count_next = count;
    endcase
  end

endmodule

// File: rtl/cal_mod_counter.sv
// Modulo counter stage with programmable wrap limit and same-cycle carry for cascading.
// Define CAL_CNT_DOWN_EN to add the dn port and down counting with borrow.
module cal_mod_counter
  import cal_pkg::*;
#(
  parameter int BITS    = 5,
  parameter int MIN_VAL = 0,
  parameter int RST_VAL = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            ld,
  input  logic [BITS-1:0] ld_val,
  input  logic [BITS-1:0] lim,
`ifdef CAL_CNT_DOWN_EN
  input  logic            dn,
`endif
  output logic [BITS-1:0] count,
  output logic            carry,
  output logic            ld_err
);

  localparam logic [BITS-1:0] RST_V = BITS'(RST_VAL);

  logic [BITS-1:0] count_reg;
  logic [BITS-1:0] count_next;
  logic            ld_err_reg;
  logic            ld_err_next;
  logic            carry_raw;
  logic            dn_int;

`ifdef CAL_CNT_DOWN_EN
  assign dn_int = dn;
`else
  assign dn_int = 1'b0;
`endif

  cal_cnt_next #(
    .BITS    (BITS),
    .MIN_VAL (MIN_VAL)
  ) u_next (
    .en          (en),
    .ld          (ld),
    .dn          (dn_int),
    .count       (count_reg),
    .ld_val      (ld_val),
    .lim         (lim),
    .count_next  (count_next),
    .carry       (carry_raw),
    .ld_err_next (ld_err_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= RST_V;
      ld_err_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      ld_err_reg <= ld_err_next;
    end
  end

  // Keep carry quiet during reset so downstream stages never see a spurious increment.
  assign carry  = carry_raw & ~rst;
  assign count  = count_reg;
  assign ld_err = ld_err_reg;

endmodule

// File: tb/tb_cal_mod_counter.sv
// Directed and randomized bench for cal_mod_counter against a rule-level reference model.
module tb_cal_mod_counter;
  import cal_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Instance A: BITS=5, MIN_VAL=0, RST_VAL=0
  logic       a_rst, a_en, a_ld, a_carry, a_ld_err;
  logic [4:0] a_ld_val, a_lim, a_count;
  // Instance B: day-style counter, BITS=5, MIN_VAL=1, RST_VAL=1
  logic       b_rst, b_en, b_ld, b_carry, b_ld_err;
  logic [4:0] b_ld_val, b_lim, b_count;
`ifdef CAL_CNT_DOWN_EN
  logic       a_dn, b_dn;
`endif

  int a_m, b_m;

  cal_mod_counter #(.BITS(5), .MIN_VAL(0), .RST_VAL(0)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .ld(a_ld), .ld_val(a_ld_val), .lim(a_lim),
`ifdef CAL_CNT_DOWN_EN
    .dn(a_dn),
`endif
    .count(a_count), .carry(a_carry), .ld_err(a_ld_err)
  );

  cal_mod_counter #(.BITS(5), .MIN_VAL(1), .RST_VAL(1)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .ld(b_ld), .ld_val(b_ld_val), .lim(b_lim),
`ifdef CAL_CNT_DOWN_EN
    .dn(b_dn),
`endif
    .count(b_count), .carry(b_carry), .ld_err(b_ld_err)
  );

  // Cascade sec -> min -> hour, each carry feeding the next stage's enable.
  localparam int CAS_LIM [3] = '{CAL_SEC_LIM, CAL_MIN_LIM, CAL_HOUR_LIM};
  logic       c_en, c_ld;
  logic [5:0] c_ld_val [3];
  logic [5:0] cas_cnt  [3];
  logic [2:0] cas_en, cas_cy, cas_err;

  for (genvar gi = 0; gi < 3; gi++) begin : g_cas
    if (gi == 0) begin : g_first
      assign cas_en[gi] = c_en;
    end else begin : g_chain
      assign cas_en[gi] = cas_cy[gi-1];
    end
    cal_mod_counter #(.BITS(6), .MIN_VAL(0), .RST_VAL(0)) dut_c (
      .clk(clk), .rst(a_rst), .en(cas_en[gi]), .ld(c_ld), .ld_val(c_ld_val[gi]),
      .lim(6'(CAS_LIM[gi])),
`ifdef CAL_CNT_DOWN_EN
      .dn(1'b0),
`endif
      .count(cas_cnt[gi]), .carry(cas_cy[gi]), .ld_err(cas_err[gi])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: next count, carry and load error straight from the counting rules.
  function automatic void ref_next(input int cnt, input int ld, input int ldv, input int en,
                                   input int lim, input int mn, input int dn,
                                   output int nxt, output int cy, output int er);
    int el;
    el  = (lim < mn) ? mn : lim;
    nxt = cnt; cy = 0; er = 0;
    if (ld != 0) begin
      if (ldv >= mn && ldv <= el) nxt = ldv;
      else begin nxt = mn; er = 1; end
    end else if (en != 0 && dn == 0) begin
      if (cnt >= el) begin nxt = mn; cy = 1; end
      else nxt = cnt + 1;
    end else if (en != 0) begin
      if (cnt <= mn)     begin nxt = el; cy = 1; end
      else if (cnt > el) nxt = el;
      else               nxt = cnt - 1;
    end
  endfunction

  // One clock of activity on A (sel=0) or B (sel=1); the other instance idles.
  task automatic step(input int sel, input int ld, input int ldv, input int en,
                      input int lim, input int dn, input string tag);
    int nxt, cy, er;
    @(negedge clk);
    a_ld = 1'b0; a_en = 1'b0; b_ld = 1'b0; b_en = 1'b0;
    if (sel == 0) begin
      a_ld = 1'(ld); a_ld_val = 5'(ldv); a_en = 1'(en); a_lim = 5'(lim);
`ifdef CAL_CNT_DOWN_EN
      a_dn = 1'(dn);
`endif
      ref_next(a_m, ld, ldv, en, lim, 0, dn, nxt, cy, er);
    end else begin
      b_ld = 1'(ld); b_ld_val = 5'(ldv); b_en = 1'(en); b_lim = 5'(lim);
`ifdef CAL_CNT_DOWN_EN
      b_dn = 1'(dn);
`endif
      ref_next(b_m, ld, ldv, en, lim, 1, dn, nxt, cy, er);
    end
    #1 chk({tag, ".carry"}, (sel == 0) ? a_carry : b_carry, cy);
    @(posedge clk); #1;
    if (sel == 0) a_m = nxt; else b_m = nxt;
    chk({tag, ".count"},  (sel == 0) ? a_count  : b_count,  nxt);
    chk({tag, ".ld_err"}, (sel == 0) ? a_ld_err : b_ld_err, er);
  endtask

  initial begin
    int dn_r;
    a_rst = 1'b1; b_rst = 1'b1; a_en = 1'b1; b_en = 1'b1; a_ld = 1'b0; b_ld = 1'b0;
    a_ld_val = '0; b_ld_val = '0; a_lim = 5'd23; b_lim = 5'd1;
    c_en = 1'b0; c_ld = 1'b0;
    for (int i = 0; i < 3; i++) c_ld_val[i] = '0;
`ifdef CAL_CNT_DOWN_EN
    a_dn = 1'b0; b_dn = 1'b0;
`endif

    // 1: reset held two cycles with en=1
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst.a_count", a_count, 0);
      chk("rst.b_count", b_count, 1);
      chk("rst.a_ld_err", a_ld_err, 0);
      chk("rst.b_ld_err", b_ld_err, 0);
      chk("rst.a_carry", a_carry, 0);
      chk("rst.b_carry", b_carry, 0);
    end
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; a_en = 1'b0; b_en = 1'b0;
    a_m = 0; b_m = 1;

    // 2: wrap at lim=23 from 0
    for (int i = 0; i < 25; i++) step(0, 0, 0, 1, 23, 0, "wrap23");

    // Full-range limit wraps to MIN_VAL
    step(0, 1, 31, 0, 31, 0, "a_ld31");
    step(0, 0, 0, 1, 31, 0, "a_wrap31");
    step(1, 1, 31, 0, 31, 0, "b_ld31");
    step(1, 0, 0, 1, 31, 0, "b_wrap31");

    // 3: day counter
    step(1, 1, 27, 0, 28, 0, "day_ld27");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 28, 0, "day_run");
    step(1, 1, 30, 0, 31, 0, "day_ld30");
    step(1, 0, 0, 1, 28, 0, "day_limdrop");

    // 4: load errors and load priority
    step(1, 1, 0, 0, 28, 0, "lderr_low");
    step(1, 0, 0, 0, 28, 0, "lderr_clear");
    step(1, 1, 29, 0, 28, 0, "lderr_high");
    step(1, 1, 5, 1, 28, 0, "ld_and_en");
    step(1, 0, 0, 1, 0, 0, "elim_clamp");

`ifdef CAL_CNT_DOWN_EN
    // 6: down mode
    step(1, 1, 1, 0, 12, 0, "dn_ld1");
    step(1, 0, 0, 1, 12, 1, "dn_borrow");
    step(1, 0, 0, 1, 12, 1, "dn_dec");
    step(1, 1, 10, 0, 31, 0, "dn_ld10");
    step(1, 0, 0, 1, 5, 1, "dn_clamp");
`endif

    // Mid-run reset on B
    step(1, 1, 20, 0, 31, 0, "mid_ld20");
    @(negedge clk);
    b_rst = 1'b1; b_en = 1'b1; b_lim = 5'd20;
    #1 chk("mid_rst.carry", b_carry, 0);
    @(posedge clk); #1;
    chk("mid_rst.count", b_count, 1);
    @(negedge clk);
    b_rst = 1'b0; b_en = 1'b0; b_m = 1;

    // 5: cascade from 23:59:59, then from 00:00:59
    @(negedge clk);
    c_ld = 1'b1; c_ld_val[0] = 6'd59; c_ld_val[1] = 6'd59; c_ld_val[2] = 6'd23;
    @(negedge clk);
    c_ld = 1'b0; c_en = 1'b1;
    #1 chk("cas1.carries", cas_cy, 3'b111);
    @(posedge clk); #1;
    chk("cas1.sec", cas_cnt[0], 0);
    chk("cas1.min", cas_cnt[1], 0);
    chk("cas1.hour", cas_cnt[2], 0);
    @(negedge clk);
    c_en = 1'b0; c_ld = 1'b1; c_ld_val[0] = 6'd59; c_ld_val[1] = 6'd0; c_ld_val[2] = 6'd0;
    @(negedge clk);
    c_ld = 1'b0; c_en = 1'b1;
    #1 chk("cas2.carries", cas_cy, 3'b001);
    @(posedge clk); #1;
    chk("cas2.sec", cas_cnt[0], 0);
    chk("cas2.min", cas_cnt[1], 1);
    chk("cas2.hour", cas_cnt[2], 0);
    @(negedge clk);
    c_en = 1'b0;

    // Randomized traffic on both instances, limits changing every cycle
    for (int i = 0; i < 300; i++) begin
      dn_r = 0;
`ifdef CAL_CNT_DOWN_EN
      dn_r = int'($urandom_range(0, 1));
`endif
      step(int'($urandom_range(0, 1)), int'($urandom_range(0, 5) == 0),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6)),
           dn_r, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
